cascade_counter_n: RTL and testbench

//  Parametrised N-digit synchronous up/down counter; each digit counts modulo MODULUS (10 = BCD, 16 = hex).

---
 rtl/cascade_counter_n.sv | 109 ++++++++++
 tb/tb_cascade_counter_n.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cascade_counter_n.sv
// cascade_counter_n: N-digit synchronous up/down counter, each digit modulo MODULUS.
// Every digit sees a combinational enable from the digits below it, so the whole
// counter moves in one edge with no per-stage carry lag.
// Optional saturating mode: define CASCADE_CNT_HOLD_EN to hold at terminal instead of wrapping.
module cascade_counter_n #(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  localparam int CW     = DIGITS * DIGIT_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic              start_stop,
  input  logic              up_down,
  input  logic [CW-1:0]     data,
  output logic [CW-1:0]     count,
  output logic [DIGITS-1:0] carry,
  output logic              tc,
  output logic              load_err
);

  // Bad parameters must not produce a silently wrong counter.
  if (MODULUS < 2 || MODULUS > (1 << DIGIT_W) || DIGITS < 1) begin : g_bad_params
    $error("cascade_counter_n: illegal parameters DIGIT_W=%0d DIGITS=%0d MODULUS=%0d",
           DIGIT_W, DIGITS, MODULUS);
  end

  // One extra bit so MODULUS == 2**DIGIT_W still fits for the >= compare on load.
  localparam logic [DIGIT_W:0]   MOD_EXT   = (DIGIT_W+1)'(MODULUS);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(MODULUS - 1);

  logic [CW-1:0]     cnt_nxt;
  logic [DIGITS-1:0] carry_nxt;
  logic              tc_nxt;
  logic [CW-1:0]     load_val;
  logic              load_bad;

  // Next count when counting: a digit steps only while every lower digit sits at terminal.
  always_comb begin
    logic                step;
    logic [DIGIT_W-1:0]  dig;
    logic [DIGIT_W-1:0]  term;
    logic                at_term;
    cnt_nxt   = count;
    carry_nxt = '0;
    tc_nxt    = 1'b0;
    step      = start_stop;
    term      = up_down ? DIGIT_MAX : '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig     = count[i*DIGIT_W +: DIGIT_W];
      at_term = (dig == term);
      if (step) begin
        if (at_term) begin
          cnt_nxt[i*DIGIT_W +: DIGIT_W] = up_down ? '0 : DIGIT_MAX;
          carry_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i*DIGIT_W +: DIGIT_W] = up_down ? dig + DIGIT_W'(1) : dig - DIGIT_W'(1);
        end
      end
      step = step & at_term;
    end
    // After the loop, step is high only if counting with every digit at terminal.
    tc_nxt = carry_nxt[DIGITS-1];
`ifdef CASCADE_CNT_HOLD_EN
    if (step) begin
      cnt_nxt   = count;
      carry_nxt = '0;
      tc_nxt    = 1'b1;
    end
`endif
  end

  // Load value with out-of-range digits clamped to MODULUS-1, and the error flag.
  always_comb begin
    load_val = data;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, data[i*DIGIT_W +: DIGIT_W]} >= MOD_EXT) begin
        load_val[i*DIGIT_W +: DIGIT_W] = DIGIT_MAX;
        load_bad = 1'b1;
      end
    end
  end

  // State register: clear > load > count; every output is a flop.
  always_ff @(posedge clock) begin
    if (clear) begin
      count    <= '0;
      carry    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_val;
      carry    <= '0;
      tc       <= 1'b0;
      load_err <= load_bad;
    end else if (start_stop) begin
      count    <= cnt_nxt;
      carry    <= carry_nxt;
      tc       <= tc_nxt;
      load_err <= 1'b0;
    end else begin
      carry    <= '0;
      tc       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cascade_counter_n.sv
// Testbench for cascade_counter_n (default parameters: 2 BCD digits).
// The reference model keeps the count as a plain integer modulo MODULUS**DIGITS.
module tb_cascade_counter_n;

  localparam int DW  = 4;
  localparam int N   = 2;
  localparam int M   = 10;
  localparam int CW  = N * DW;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic          start_stop = 1'b0;
  logic          up_down = 1'b0;
  logic [CW-1:0] data = '0;
  logic [CW-1:0] count;
  logic [N-1:0]  carry;
  logic          tc;
  logic          load_err;

  int n_pass  = 0;
  int n_total = 0;

  int          m_val = 0;
  logic [N-1:0] m_carry = '0;
  bit          m_tc = 0;
  bit          m_err = 0;

  cascade_counter_n #(.DIGIT_W(DW), .DIGITS(N), .MODULUS(M)) dut (
    .clock(clock), .clear(clear), .load(load), .start_stop(start_stop),
    .up_down(up_down), .data(data), .count(count), .carry(carry),
    .tc(tc), .load_err(load_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int total_range();
    int t = 1;
    for (int i = 0; i < N; i++) t *= M;
    return t;
  endfunction

  function automatic logic [CW-1:0] to_digits(input int v);
    logic [CW-1:0] r = '0;
    int rem = v;
    for (int i = 0; i < N; i++) begin
      r[i*DW +: DW] = DW'(rem % M);
      rem = rem / M;
    end
    return r;
  endfunction

  // Reference behaviour for one rising edge, in integer terms.
  task automatic model_edge(input bit clr, input bit ld, input bit ss, input bit ud,
                            input logic [CW-1:0] d);
    int tot = total_range();
    if (clr) begin
      m_val = 0; m_carry = '0; m_tc = 0; m_err = 0;
    end else if (ld) begin
      int v = 0;
      int w = 1;
      bit bad = 0;
      for (int i = 0; i < N; i++) begin
        int dig = int'(d[i*DW +: DW]);
        if (dig >= M) begin dig = M - 1; bad = 1; end
        v += dig * w;
        w *= M;
      end
      m_val = v; m_carry = '0; m_tc = 0; m_err = bad;
    end else if (ss) begin
      bit at_end = ud ? (m_val == tot - 1) : (m_val == 0);
      m_err = 0;
`ifdef CASCADE_CNT_HOLD_EN
      if (at_end) begin
        m_carry = '0; m_tc = 1;
      end else
`endif
      begin
        int p = 1;
        for (int i = 0; i < N; i++) begin
          p *= M;
          m_carry[i] = ud ? ((m_val % p) == p - 1) : ((m_val % p) == 0);
        end
        m_val = ud ? (m_val + 1) % tot : (m_val + tot - 1) % tot;
        m_tc  = at_end;
      end
    end else begin
      m_carry = '0; m_tc = 0;
    end
  endtask

  // Drive one cycle, apply the model on the edge, sample outputs 1 time unit later.
  task automatic cyc(input string tag, input bit clr, input bit ld, input bit ss,
                     input bit ud, input logic [CW-1:0] d);
    clear = clr; load = ld; start_stop = ss; up_down = ud; data = d;
    @(posedge clock);
    model_edge(clr, ld, ss, ud, d);
    #1;
    check({tag, ".count"},    32'(count),    32'(to_digits(m_val)));
    check({tag, ".carry"},    32'(carry),    32'(m_carry));
    check({tag, ".tc"},       32'(tc),       32'(m_tc));
    check({tag, ".load_err"}, 32'(load_err), 32'(m_err));
  endtask

  initial begin
    // Reset wins over a simultaneous load.
    cyc("clr_ld", 1, 1, 0, 0, 8'h57);
    check("reset_count", 32'(count), 32'h00);
    check("reset_flags", 32'({carry, tc, load_err}), 32'h0);

    // Up across the top: 98 -> 99 -> 00 with full carry and one-cycle tc.
    cyc("ld98", 0, 1, 0, 1, 8'h98);
    cyc("up1", 0, 0, 1, 1, 8'h00);
    check("up1_count", 32'(count), 32'h99);
    cyc("up2", 0, 0, 1, 1, 8'h00);
`ifndef CASCADE_CNT_HOLD_EN
    check("wrap_count", 32'(count), 32'h00);
    check("wrap_carry", 32'(carry), 32'h3);
    check("wrap_tc", 32'(tc), 32'h1);
`endif
    cyc("up3", 0, 0, 1, 1, 8'h00);

    // Down counting, lower-digit borrow and full underflow.
    cyc("ld10", 0, 1, 0, 0, 8'h10);
    cyc("dn10", 0, 0, 1, 0, 8'h00);
    check("dn10_count", 32'(count), 32'h09);
    cyc("ld00", 0, 1, 0, 0, 8'h00);
    cyc("dn00", 0, 0, 1, 0, 8'h00);
`ifndef CASCADE_CNT_HOLD_EN
    check("dn00_count", 32'(count), 32'h99);
    check("dn00_tc", 32'(tc), 32'h1);
`endif

    // Out-of-range load is clamped; error clears on the next counting edge.
    cyc("ldC3", 0, 1, 0, 1, 8'hC3);
    check("ldC3_count", 32'(count), 32'h93);
    check("ldC3_err", 32'(load_err), 32'h1);
    cyc("hold_err", 0, 0, 0, 1, 8'h00);
    cyc("cnt_err", 0, 0, 1, 1, 8'h00);
    check("err_clear", 32'(load_err), 32'h0);

    // Mid-run clear over load, hold, and direction flip.
    cyc("ld42", 0, 1, 0, 1, 8'h42);
    cyc("run42", 0, 0, 1, 1, 8'h00);
    cyc("clr_mid", 1, 1, 1, 1, 8'h77);
    check("clr_mid_count", 32'(count), 32'h00);
    cyc("ld55", 0, 1, 0, 1, 8'h55);
    cyc("hold", 0, 0, 0, 1, 8'h00);
    check("hold_count", 32'(count), 32'h55);
    cyc("upA", 0, 0, 1, 1, 8'h00);
    cyc("flip", 0, 0, 1, 0, 8'h00);
    check("flip_count", 32'(count), 32'h55);

    // Near-terminal run for saturating/wrap behaviour and reversal.
    cyc("ld98b", 0, 1, 0, 1, 8'h98);
    for (int i = 0; i < 5; i++) cyc("sat", 0, 0, 1, 1, 8'h00);
    cyc("rev", 0, 0, 1, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit clr = ($urandom_range(0, 31) == 0);
      bit ld  = ($urandom_range(0, 9) == 0);
      bit ss  = ($urandom_range(0, 5) != 0);
      bit ud  = ($urandom_range(0, 7) != 0) ? up_down : ~up_down;
      logic [CW-1:0] d = CW'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'h99 - CW'($urandom_range(0, 1));
      cyc("rand", clr, ld, ss, ud, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
